if_stage: RTL and testbench

Instruction-fetch stage of the five-stage pipeline: owns the program counter, drives the instruction-memory port, and holds the IF/ID pipeline register consumed by the decode stage. Applies the decode-stage control outputs (stall, branch, jump, jr, cancel_next) to hold, redirect, or squash fetch. Computes branch, jump and jr targets from the instruction currently in ID.

---
 rtl/if_stage.sv | 111 +++++++++++
 tb/tb_if_stage.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, instruction-memory port and IF/ID register.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rdy,
    input  logic        stall,
    input  logic        branch,
    input  logic        jump,
    input  logic        jr,
    input  logic        cancel_next,
    input  logic [31:0] id_rs_val,
    output logic [31:0] pc,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_wait_cnt,
`endif
    output logic [31:0] id_inst,
    output logic [31:0] id_pc4,
    output logic        id_valid
);

    logic [31:0] r_pc;
    logic [31:0] r_id_inst;
    logic [31:0] r_id_pc4;
    logic        r_id_valid;
    logic [31:0] w_pc4;
    logic [31:0] w_br_off;
    logic [31:0] w_target;

    assign w_pc4    = r_pc + 32'd4;
    assign w_br_off = {{14{r_id_inst[15]}}, r_id_inst[15:0], 2'b00};

    // Target comes from the instruction currently in ID, not from the fetch data.
    always_comb begin
        w_target = r_id_pc4 + w_br_off;
        if (jr)
            w_target = id_rs_val;
        else if (jump)
            w_target = {r_id_pc4[31:28], r_id_inst[25:0], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_id_inst  <= NOP;
            r_id_pc4   <= '0;
            r_id_valid <= 1'b0;
        end else if (stall) begin
            r_pc       <= r_pc;
        end else if (branch) begin
            r_pc <= w_target;
            if (cancel_next || !imem_rdy) begin
                r_id_inst  <= NOP;
                r_id_valid <= 1'b0;
            end else begin
                r_id_inst  <= imem_rdata;
                r_id_pc4   <= w_pc4;
                r_id_valid <= 1'b1;
            end
        end else if (imem_rdy) begin
            r_pc       <= w_pc4;
            r_id_inst  <= imem_rdata;
            r_id_pc4   <= w_pc4;
            r_id_valid <= 1'b1;
        end else begin
            r_id_inst  <= NOP;
            r_id_valid <= 1'b0;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic [31:0] r_wait_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_wait_cnt  <= '0;
        end else begin
            if (stall)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (branch && cancel_next && !stall)
                r_flush_cnt <= r_flush_cnt + 32'd1;
            if (!imem_rdy && !stall)
                r_wait_cnt  <= r_wait_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_flush_cnt = r_flush_cnt;
    assign perf_wait_cnt  = r_wait_cnt;
`endif

    assign imem_req  = rst_n;
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign id_inst   = r_id_inst;
    assign id_pc4    = r_id_pc4;
    assign id_valid  = r_id_valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed vector bench for if_stage: per-cycle input records with hand-computed
// expected PC and IF/ID contents, plus reset-release and fetch-port stability sequences.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rdy;
    logic        stall, branch, jump, jr, cancel_next;
    logic [31:0] id_rs_val;
    logic [31:0] pc, id_inst, id_pc4;
    logic        id_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_wait_cnt;
`endif

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h0000_0000), .NOP(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_rdy    (imem_rdy),
        .stall       (stall),
        .branch      (branch),
        .jump        (jump),
        .jr          (jr),
        .cancel_next (cancel_next),
        .id_rs_val   (id_rs_val),
        .pc          (pc),
`ifdef IF_PERF_CNT_EN
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt),
        .perf_wait_cnt  (perf_wait_cnt),
`endif
        .id_inst     (id_inst),
        .id_pc4      (id_pc4),
        .id_valid    (id_valid)
    );

    typedef struct {
        logic        rn, s, b, j, r, c, rdy;
        logic [31:0] rdata, rs;
        logic [31:0] e_pc, e_inst, e_pc4;
        logic        e_valid;
        logic        chk_perf;
        logic [31:0] e_ps, e_pf, e_pw;
    } vec_t;

    localparam int NV = 24;
    vec_t vt [NV];

    function automatic vec_t mk(input logic rn, s, b, j, r, c, rdy,
                                input logic [31:0] rdata, rs, e_pc, e_inst, e_pc4,
                                input logic e_valid);
        vec_t t;
        t.rn = rn; t.s = s; t.b = b; t.j = j; t.r = r; t.c = c; t.rdy = rdy;
        t.rdata = rdata; t.rs = rs;
        t.e_pc = e_pc; t.e_inst = e_inst; t.e_pc4 = e_pc4; t.e_valid = e_valid;
        t.chk_perf = 1'b0; t.e_ps = '0; t.e_pf = '0; t.e_pw = '0;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    initial begin
        //            rn s b j r c rdy rdata          rs             pc             inst           pc4            v
        vt[0]  = mk(1,0,0,0,0,0,1, 32'h1111_0000, 32'h0,         32'h0000_0004, 32'h1111_0000, 32'h0000_0004, 1);
        vt[1]  = mk(1,0,0,0,0,0,1, 32'h1111_0004, 32'h0,         32'h0000_0008, 32'h1111_0004, 32'h0000_0008, 1);
        vt[2]  = mk(1,0,0,0,0,0,1, 32'h1111_0008, 32'h0,         32'h0000_000C, 32'h1111_0008, 32'h0000_000C, 1);
        vt[3]  = mk(1,0,0,0,0,0,1, 32'h1111_000C, 32'h0,         32'h0000_0010, 32'h1111_000C, 32'h0000_0010, 1);
        // two stall cycles; the second also raises branch/cancel which must be ignored
        vt[4]  = mk(1,1,0,0,0,0,1, 32'h1111_0010, 32'h0,         32'h0000_0010, 32'h1111_000C, 32'h0000_0010, 1);
        vt[5]  = mk(1,1,1,0,0,1,1, 32'h1111_0010, 32'h0,         32'h0000_0010, 32'h1111_000C, 32'h0000_0010, 1);
        vt[6]  = mk(1,0,0,0,0,0,1, 32'h1111_0010, 32'h0,         32'h0000_0014, 32'h1111_0010, 32'h0000_0014, 1);
        vt[7]  = mk(1,0,0,0,0,0,1, 32'h1111_0014, 32'h0,         32'h0000_0018, 32'h1111_0014, 32'h0000_0018, 1);
        vt[8]  = mk(1,0,0,0,0,0,1, 32'h1111_0018, 32'h0,         32'h0000_001C, 32'h1111_0018, 32'h0000_001C, 1);
        // beq imm=0xFFFE fetched at 0x1C -> ID with pc4=0x20, target 0x18
        vt[9]  = mk(1,0,0,0,0,0,1, 32'h1000_FFFE, 32'h0,         32'h0000_0020, 32'h1000_FFFE, 32'h0000_0020, 1);
        vt[10] = mk(1,0,1,0,0,1,1, 32'h1111_0020, 32'h0,         32'h0000_0018, 32'h0000_0000, 32'h0000_0020, 0);
        vt[11] = mk(1,0,0,0,0,0,1, 32'h2222_0018, 32'h0,         32'h0000_001C, 32'h2222_0018, 32'h0000_001C, 1);
        // jr with delay slot kept (cancel_next=0)
        vt[12] = mk(1,0,1,0,1,0,1, 32'h3333_001C, 32'h0000_0080, 32'h0000_0080, 32'h3333_001C, 32'h0000_0020, 1);
        // jr and jump both high: register form wins
        vt[13] = mk(1,0,1,1,1,1,1, 32'h3333_0080, 32'h1000_003C, 32'h1000_003C, 32'h0000_0000, 32'h0000_0020, 0);
        vt[14] = mk(1,0,0,0,0,0,1, 32'h0800_0100, 32'h0,         32'h1000_0040, 32'h0800_0100, 32'h1000_0040, 1);
        // j index 0x100 with pc4=0x1000_0040 -> 0x1000_0400
        vt[15] = mk(1,0,1,1,0,1,1, 32'h3333_0040, 32'h0000_0080, 32'h1000_0400, 32'h0000_0000, 32'h1000_0040, 0);
        vt[16] = mk(1,0,0,0,0,0,0, 32'hDEAD_BEEF, 32'h0,         32'h1000_0400, 32'h0000_0000, 32'h1000_0040, 0);
        vt[17] = mk(1,0,0,0,0,0,1, 32'h1000_0004, 32'h0,         32'h1000_0404, 32'h1000_0004, 32'h1000_0404, 1);
        // branch during wait: pc takes target at once, three bubbles, then target instruction
        vt[18] = mk(1,0,1,0,0,0,0, 32'hDEAD_BEEF, 32'h0,         32'h1000_0414, 32'h0000_0000, 32'h1000_0404, 0);
        vt[19] = mk(1,0,0,0,0,0,0, 32'hDEAD_BEEF, 32'h0,         32'h1000_0414, 32'h0000_0000, 32'h1000_0404, 0);
        vt[20] = mk(1,0,0,0,0,0,0, 32'hDEAD_BEEF, 32'h0,         32'h1000_0414, 32'h0000_0000, 32'h1000_0404, 0);
        vt[21] = mk(1,0,0,0,0,0,1, 32'h4444_0414, 32'h0,         32'h1000_0418, 32'h4444_0414, 32'h1000_0418, 1);
        // reset during a stall with a pending branch
        vt[22] = mk(0,1,1,0,0,1,0, 32'hDEAD_BEEF, 32'h0,         32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0);
        vt[23] = mk(1,0,0,0,0,0,1, 32'h5555_0000, 32'h0,         32'h0000_0004, 32'h5555_0000, 32'h0000_0004, 1);
        vt[21].chk_perf = 1'b1; vt[21].e_ps = 32'd2; vt[21].e_pf = 32'd3; vt[21].e_pw = 32'd4;
        vt[22].chk_perf = 1'b1;
        vt[23].chk_perf = 1'b1;

        rst_n = 1'b0; stall = 1'b0; branch = 1'b0; jump = 1'b0; jr = 1'b0;
        cancel_next = 1'b0; imem_rdy = 1'b1; imem_rdata = 32'hFFFF_FFFF; id_rs_val = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", -1, {31'b0, imem_req}, 32'd0);
        chk("rst_pc", -1, pc, 32'h0);
        chk("rst_inst", -1, id_inst, 32'h0);
        chk("rst_pc4", -1, id_pc4, 32'h0);
        chk("rst_valid", -1, {31'b0, id_valid}, 32'd0);
`ifdef IF_PERF_CNT_EN
        chk("rst_perf", -1, perf_stall_cnt | perf_flush_cnt | perf_wait_cnt, 32'h0);
`endif
        rst_n = 1'b1;
        #1;
        chk("rel_req", -1, {31'b0, imem_req}, 32'd1);
        chk("rel_addr", -1, imem_addr, 32'h0);

        for (int i = 0; i < NV; i++) begin
            rst_n = vt[i].rn; stall = vt[i].s; branch = vt[i].b; jump = vt[i].j;
            jr = vt[i].r; cancel_next = vt[i].c; imem_rdy = vt[i].rdy;
            imem_rdata = vt[i].rdata; id_rs_val = vt[i].rs;
            @(posedge clk);
            #1;
            chk("pc", i, pc, vt[i].e_pc);
            chk("imem_addr", i, imem_addr, vt[i].e_pc);
            chk("id_inst", i, id_inst, vt[i].e_inst);
            chk("id_pc4", i, id_pc4, vt[i].e_pc4);
            chk("id_valid", i, {31'b0, id_valid}, {31'b0, vt[i].e_valid});
`ifdef IF_PERF_CNT_EN
            if (vt[i].chk_perf) begin
                chk("perf_stall", i, perf_stall_cnt, vt[i].e_ps);
                chk("perf_flush", i, perf_flush_cnt, vt[i].e_pf);
                chk("perf_wait", i, perf_wait_cnt, vt[i].e_pw);
            end
`endif
        end

        // imem_rdy toggling within a cycle must not disturb the fetch address
        rst_n = 1'b1; stall = 1'b0; branch = 1'b0; jump = 1'b0; jr = 1'b0; cancel_next = 1'b0;
        imem_rdy = 1'b0;
        #1;
        chk("addr_rdy0", NV, imem_addr, 32'h0000_0004);
        chk("req_rdy0", NV, {31'b0, imem_req}, 32'd1);
        imem_rdy = 1'b1;
        #1;
        chk("addr_rdy1", NV, imem_addr, 32'h0000_0004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
